uart_hex_tx: RTL and testbench

- UART transmitter that dumps a 16-bit debug word from the CPU board to a host terminal.
- This is the host-facing output direction for the value the board already shows on the seven-segment display.
- On a start request it latches the word and sends it as 4 uppercase ASCII hex characters, MSB nibble first, followed by CR (0x0D) and LF (0x0A).
- Sits beside the display path in the board top level and shares the system clock; start is driven from a debounced button or from the CPU.

---
 rtl/uart_hex_tx.sv | 191 +++++++++++++++++++
 tb/tb_uart_hex_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_tx.sv
// uart_hex_tx: latches a 16-bit debug word and sends it to a host terminal
// as four uppercase ASCII hex digits (MSB nibble first), then CR and LF.
// Line format is 8N1. Define UART_HEX_TX_PARITY_EN to insert an even-parity
// bit after bit 7 of each character.
module uart_hex_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned     BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      LAST_BIT  = 3'd7;
    localparam logic [2:0]      LAST_CHAR = 3'd5;

    // ST_NEXT is resolved on the STOP exit edge and is never registered.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_NEXT   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [BAUD_W-1:0]   r_baud;
    logic [BAUD_W-1:0]   w_baud_nx;
    logic [2:0]          r_bit_idx;
    logic [2:0]          w_bit_nx;
    logic [2:0]          r_char_idx;
    logic [2:0]          w_char_nx;
    logic [15:0]         r_shadow;
    logic [15:0]         w_shadow_nx;
    logic                r_tx;
    logic                w_tx_nx;
    logic                r_busy;
    logic                w_busy_nx;
    logic                r_done;
    logic                w_done_nx;
    logic                w_bit_tick;
    logic [7:0]          w_char_byte_nx;

    // Nibble to uppercase ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    // Character to send for a given position in the message.
    function automatic logic [7:0] char_sel(input logic [2:0] idx, input logic [15:0] word);
        case (idx)
            3'd0:    return hex_ascii(word[15:12]);
            3'd1:    return hex_ascii(word[11:8]);
            3'd2:    return hex_ascii(word[7:4]);
            3'd3:    return hex_ascii(word[3:0]);
            3'd4:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    assign w_bit_tick = (r_baud == BAUD_LAST);

    // Next-state logic: bit timing, bit/char sequencing, busy/done.
    always_comb begin
        w_state_nx  = r_state;
        w_baud_nx   = r_baud;
        w_bit_nx    = r_bit_idx;
        w_char_nx   = r_char_idx;
        w_shadow_nx = r_shadow;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_shadow_nx = data;
                    w_char_nx   = 3'd0;
                    w_bit_nx    = 3'd0;
                    w_baud_nx   = '0;
                    w_busy_nx   = 1'b1;
                    w_state_nx  = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_tick) begin
                    w_baud_nx  = '0;
                    w_bit_nx   = 3'd0;
                    w_state_nx = ST_DATA;
                end else begin
                    w_baud_nx = r_baud + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (w_bit_tick) begin
                    w_baud_nx = '0;
                    if (r_bit_idx == LAST_BIT) begin
`ifdef UART_HEX_TX_PARITY_EN
                        w_state_nx = ST_PARITY;
`else
                        w_state_nx = ST_STOP;
`endif
                    end else begin
                        w_bit_nx = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_nx = r_baud + BAUD_W'(1);
                end
            end
`ifdef UART_HEX_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_tick) begin
                    w_baud_nx  = '0;
                    w_state_nx = ST_STOP;
                end else begin
                    w_baud_nx = r_baud + BAUD_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_tick) begin
                    w_baud_nx = '0;
                    // Next-character decision folded into the stop-bit exit edge.
                    if (r_char_idx == LAST_CHAR) begin
                        w_state_nx = ST_IDLE;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_char_nx  = r_char_idx + 3'd1;
                        w_state_nx = ST_START;
                    end
                end else begin
                    w_baud_nx = r_baud + BAUD_W'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_baud_nx  = '0;
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    // Line level for the upcoming cycle, derived from the next state.
    always_comb begin
        w_tx_nx        = 1'b1;
        w_char_byte_nx = char_sel(w_char_nx, w_shadow_nx);
        case (w_state_nx)
            ST_START:  w_tx_nx = 1'b0;
            ST_DATA:   w_tx_nx = w_char_byte_nx[w_bit_nx];
            ST_PARITY: w_tx_nx = ^w_char_byte_nx;
            default:   w_tx_nx = 1'b1;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= 3'd0;
            r_char_idx <= 3'd0;
            r_shadow   <= 16'h0000;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_baud     <= w_baud_nx;
            r_bit_idx  <= w_bit_nx;
            r_char_idx <= w_char_nx;
            r_shadow   <= w_shadow_nx;
            r_tx       <= w_tx_nx;
            r_busy     <= w_busy_nx;
            r_done     <= w_done_nx;
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_uart_hex_tx.sv
// Directed bench for uart_hex_tx at CLKS_PER_BIT=4. Follows
// UART_HEX_TX_PARITY_EN so the same bench covers both frame formats.
module tb_uart_hex_tx;

    localparam int unsigned CPB = 4;
`ifdef UART_HEX_TX_PARITY_EN
    localparam int unsigned FRAME = 11;
`else
    localparam int unsigned FRAME = 10;
`endif
    localparam int unsigned MSG_CYC = 6 * FRAME * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] data;
    logic        tx;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    uart_hex_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Count done pulses, one per high cycle.
    always @(negedge clk) begin
        if (done === 1'b1) n_done = n_done + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Receive one 6-character message. Precondition: the next rising edge
    // is the accepting edge. Returns at the negedge of the cycle after busy
    // should have fallen.
    task automatic rx_msg(output logic [47:0] got, output int ferr, output int bcnt);
        logic [7:0] b;
        logic       s;
        got  = '0;
        ferr = 0;
        bcnt = 0;
        s    = 1'b0;
        for (int c = 0; c < 6; c++) begin
            b = 8'h00;
            for (int j = 0; j < int'(FRAME); j++) begin
                for (int k = 0; k < int'(CPB); k++) begin
                    @(negedge clk);
                    if (busy === 1'b1) bcnt++;
                    if (k == 1) s = tx;
                end
                if (j == 0) begin
                    if (s !== 1'b0) ferr++;
                end else if (j <= 8) begin
                    b[j-1] = s;
                end
`ifdef UART_HEX_TX_PARITY_EN
                else if (j == 9) begin
                    if (s !== ^b) ferr++;
                end
`endif
                else begin
                    if (s !== 1'b1) ferr++;
                end
            end
            got = {got[39:0], b};
        end
        @(negedge clk);
    endtask

    task automatic run_msg(input string tag, input logic [47:0] exp);
        logic [47:0] got;
        int          ferr;
        int          bcnt;
        int          d0;
        d0 = n_done;
        rx_msg(got, ferr, bcnt);
        check({tag, "_bytes"}, 64'(got), 64'(exp));
        check({tag, "_frame_err"}, 64'(ferr), 64'd0);
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'(MSG_CYC));
        check({tag, "_end_tx_busy_done"}, 64'({tx, busy, done}), 64'(3'b101));
        #1;
        check({tag, "_done_pulses"}, 64'(n_done - d0), 64'd1);
    endtask

    initial begin
        int viol;
        int d0;
        rst   = 1'b0;
        start = 1'b0;
        data  = 16'h0000;

        // Reset and idle
        repeat (3) @(negedge clk);
        check("rst_outputs", 64'({tx, busy, done}), 64'(3'b100));
        rst = 1'b1;
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if ({tx, busy, done} !== 3'b100) viol++;
        end
        check("idle_violations", 64'(viol), 64'd0);

        // Basic dump; data changes after acceptance
        @(negedge clk);
        data  = 16'h1A2F;
        start = 1'b1;
        fork
            run_msg("basic", 48'h31_41_32_46_0D_0A);
            begin
                @(posedge clk);
                #1;
                start = 1'b0;
                data  = 16'h5555;
            end
        join
        d0 = n_done;
        repeat (10) @(negedge clk);
        check("basic_no_extra_done", 64'(n_done - d0), 64'd0);

        // Start pulses during the second character are ignored
        @(negedge clk);
        data  = 16'h0000;
        start = 1'b1;
        fork
            run_msg("ignore", 48'h30_30_30_30_0D_0A);
            begin
                @(posedge clk);
                #1;
                start = 1'b0;
                data  = 16'hFFFF;
                repeat (FRAME * CPB + 6) @(negedge clk);
                start = 1'b1;
                repeat (3) @(negedge clk);
                start = 1'b0;
                repeat (CPB * 3) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        d0 = n_done;
        repeat (20) @(negedge clk);
        check("ignore_no_extra_done", 64'(n_done - d0), 64'd0);
        check("ignore_idle_busy", 64'(busy), 64'd0);

        // Back-to-back with start held high
        @(negedge clk);
        data  = 16'hBEEF;
        start = 1'b1;
        fork
            run_msg("b2b_1", 48'h42_45_45_46_0D_0A);
            begin
                @(posedge clk);
                #1;
                data = 16'h0009;
            end
        join
        fork
            run_msg("b2b_2", 48'h30_30_30_39_0D_0A);
            begin
                @(posedge clk);
                #1;
                check("b2b_second_start_tx", 64'(tx), 64'd0);
                check("b2b_second_busy", 64'(busy), 64'd1);
                start = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        check("b2b_idle_busy", 64'(busy), 64'd0);

        // Reset during DATA of character index 2
        @(negedge clk);
        data  = 16'h1200;
        start = 1'b1;
        fork
            begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            repeat (2 * FRAME * CPB + 3 * CPB + 2) @(negedge clk);
        join
        check("midrst_pre_tx", 64'(tx), 64'd0);
        check("midrst_pre_busy", 64'(busy), 64'd1);
        d0 = n_done;
        #2;
        rst = 1'b0;
        #1;
        check("midrst_outputs", 64'({tx, busy, done}), 64'(3'b100));
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_done", 64'(n_done - d0), 64'd0);
        check("midrst_idle", 64'({tx, busy, done}), 64'(3'b100));
        data  = 16'h00FF;
        start = 1'b1;
        fork
            run_msg("after_rst", 48'h30_30_46_46_0D_0A);
            begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join

        // '7' has five ones, '0' has two: parity frames checked in rx_msg
        @(negedge clk);
        data  = 16'h7000;
        start = 1'b1;
        fork
            run_msg("parity", 48'h37_30_30_30_0D_0A);
            begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
